layerio_layer_sequencer: RTL and testbench

- Per-inference controller for the layer IO memory. Sequences one read instruction and one write instruction per layer into the layerio read and write instruction FIFOs.
- Ping-pongs the read and write base offsets between the two halves of the layer IO memory.
- Tracks layer completion from the memory side and emits a one-cycle wrote_inference pulse after the last layer.
- Sits between the layer-parameter source and the layerio rd/wr instruction fifobuses, in the memory-clock domain.

---
 rtl/layerio_layer_sequencer_pkg.sv | 18 +
 rtl/layerio_layer_sequencer_channel.sv | 32 +++
 rtl/layerio_layer_sequencer.sv | 168 ++++++++++++++++
 tb/tb_layerio_layer_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/layerio_layer_sequencer_pkg.sv
// Shared types for the layer IO sequencer: FSM states, instruction payload
// and default geometry.
package layerio_layer_sequencer_pkg;

  localparam int DEFAULT_DEPTH   = 8192;
  localparam int DEFAULT_DIGIT_W = 32;
  localparam int NUM_CH          = 2;
  localparam bit CH_RD           = 1'b0;
  localparam bit CH_WR           = 1'b1;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} SeqState;

  typedef struct packed {
    logic [$clog2(DEFAULT_DEPTH)-1:0] offset;
    logic [DEFAULT_DIGIT_W-1:0]       size;
  } LayerioInstruc;

endpackage

// File: rtl/layerio_layer_sequencer_channel.sv
// One instruction output channel: loads a payload, holds it while valid&!ready,
// drops valid after the handshake. done means "empty after this edge".
module layerio_instruc_channel
  import layerio_layer_sequencer_pkg::*;
#(
  parameter type instr_t = LayerioInstruc
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  instr_t load_data,
  input  logic   ready,
  output logic   valid,
  output instr_t data,
  output logic   done
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  assign done = ~valid | ready;

endmodule

// File: rtl/layerio_layer_sequencer.sv
// Per-inference layer IO sequencer: issues one rd and one wr instruction per
// layer, ping-ponging memory halves. Optional LAYERIO_SEQ_PERF_EN adds counters.
module layerio_layer_sequencer
  import layerio_layer_sequencer_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int DIGIT_W = 32,
  parameter int LAYER_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DIGIT_W-1:0]       in_size,
  input  logic                     lp_valid,
  input  logic [DIGIT_W-1:0]       lp_total_writes,
  input  logic                     lp_islastlayer,
  output logic                     lp_ready,
  output logic                     rd_instruc_valid,
  input  logic                     rd_instruc_ready,
  output logic [$clog2(DEPTH)-1:0] rd_instruc_offset,
  output logic [DIGIT_W-1:0]       rd_instruc_size,
  output logic                     wr_instruc_valid,
  input  logic                     wr_instruc_ready,
  output logic [$clog2(DEPTH)-1:0] wr_instruc_offset,
  output logic [DIGIT_W-1:0]       wr_instruc_size,
  input  logic                     wrote_layerio_layer,
  output logic                     wrote_inference,
  output logic [LAYER_W-1:0]       layer_idx,
  output logic                     busy,
  output logic                     size_err
`ifdef LAYERIO_SEQ_PERF_EN
  ,
  output logic [DIGIT_W-1:0]       stall_cycles,
  output logic [DIGIT_W-1:0]       layer_cycles
`endif
);

  localparam int                 OFF_W    = $clog2(DEPTH);
  localparam logic [OFF_W-1:0]   HALF_OFF = OFF_W'(DEPTH / 2);
  localparam logic [DIGIT_W-1:0] HALF_SZ  = DIGIT_W'(DEPTH / 2);

  typedef struct packed {
    logic [OFF_W-1:0]   offset;
    logic [DIGIT_W-1:0] size;
  } instr_t;

  SeqState               state;
  logic [OFF_W-1:0]      rd_base;
  logic [DIGIT_W-1:0]    prev_size;
  logic                  islast, pending;
  logic                  lp_fire, layer_done;
  logic                  in_over, lp_over;
  logic [DIGIT_W-1:0]    wr_size_c;
  instr_t [NUM_CH-1:0]   ch_load, ch_q;
  logic   [NUM_CH-1:0]   ch_ready, ch_valid, ch_done;

  assign lp_fire    = (state == FETCH) & lp_valid & lp_ready;
  assign layer_done = (state == WAIT) & (wrote_layerio_layer | pending);
  assign in_over    = in_size > HALF_SZ;
  assign lp_over    = lp_total_writes > HALF_SZ;
  assign wr_size_c  = lp_over ? HALF_SZ : lp_total_writes;

  // Write half is always the opposite half of the one being read.
  assign ch_load[CH_RD] = instr_t'{offset: rd_base, size: prev_size};
  assign ch_load[CH_WR] = instr_t'{offset: rd_base ^ HALF_OFF, size: wr_size_c};
  assign ch_ready       = {wr_instruc_ready, rd_instruc_ready};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    layerio_instruc_channel #(.instr_t(instr_t)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .load      (lp_fire),
      .load_data (ch_load[c]),
      .ready     (ch_ready[c]),
      .valid     (ch_valid[c]),
      .data      (ch_q[c]),
      .done      (ch_done[c])
    );
  end

  assign rd_instruc_valid  = ch_valid[CH_RD];
  assign rd_instruc_offset = ch_q[CH_RD].offset;
  assign rd_instruc_size   = ch_q[CH_RD].size;
  assign wr_instruc_valid  = ch_valid[CH_WR];
  assign wr_instruc_offset = ch_q[CH_WR].offset;
  assign wr_instruc_size   = ch_q[CH_WR].size;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rd_base         <= '0;
      prev_size       <= '0;
      islast          <= 1'b0;
      pending         <= 1'b0;
      layer_idx       <= '0;
      lp_ready        <= 1'b0;
      busy            <= 1'b0;
      wrote_inference <= 1'b0;
      size_err        <= 1'b0;
    end else begin
      wrote_inference <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          state     <= FETCH;
          busy      <= 1'b1;
          lp_ready  <= 1'b1;
          layer_idx <= '0;
          rd_base   <= '0;
          pending   <= 1'b0;
          prev_size <= in_over ? HALF_SZ : in_size;
          if (in_over) size_err <= 1'b1;
        end
        FETCH: if (lp_fire) begin
          state    <= ISSUE;
          lp_ready <= 1'b0;
          islast   <= lp_islastlayer;
          if (lp_over) size_err <= 1'b1;
        end
        ISSUE: begin
          // Memory may finish before the slower channel handshakes.
          if (wrote_layerio_layer) pending <= 1'b1;
          if (&ch_done) state <= WAIT;
        end
        WAIT: if (layer_done) begin
          pending <= 1'b0;
          if (islast) begin
            state           <= IDLE;
            busy            <= 1'b0;
            wrote_inference <= 1'b1;
          end else begin
            state     <= FETCH;
            lp_ready  <= 1'b1;
            rd_base   <= rd_base ^ HALF_OFF;
            prev_size <= ch_q[CH_WR].size;
            layer_idx <= layer_idx + LAYER_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LAYERIO_SEQ_PERF_EN
  logic [DIGIT_W-1:0] lyr_cnt;
  logic               stall;

  assign stall = (state == ISSUE) & |(ch_valid & ~ch_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      layer_cycles <= '0;
      lyr_cnt      <= '0;
    end else if (state == IDLE && start) begin
      stall_cycles <= '0;
      layer_cycles <= '0;
      lyr_cnt      <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + DIGIT_W'(1);
      // Counts ISSUE/WAIT cycles, including the completion cycle itself.
      if (lp_fire) lyr_cnt <= '0;
      else if (layer_done) layer_cycles <= lyr_cnt + DIGIT_W'(1);
      else if (state == ISSUE || state == WAIT) lyr_cnt <= lyr_cnt + DIGIT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_layerio_layer_sequencer.sv
// Scoreboard bench for layerio_layer_sequencer at DEPTH=16 (HALF=8).
module tb_layerio_layer_sequencer;

  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int LW    = 8;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [DW-1:0] in_size = '0, lp_total_writes = '0;
  logic          lp_valid = 1'b0, lp_islastlayer = 1'b0, lp_ready;
  logic          rd_instruc_valid, rd_instruc_ready = 1'b1;
  logic [3:0]    rd_instruc_offset, wr_instruc_offset;
  logic [DW-1:0] rd_instruc_size, wr_instruc_size;
  logic          wr_instruc_valid, wr_instruc_ready = 1'b1;
  logic          wrote_layerio_layer = 1'b0, wrote_inference, busy, size_err;
  logic [LW-1:0] layer_idx;

  layerio_layer_sequencer #(.DEPTH(DEPTH), .DIGIT_W(DW), .LAYER_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_size(in_size),
    .lp_valid(lp_valid), .lp_total_writes(lp_total_writes),
    .lp_islastlayer(lp_islastlayer), .lp_ready(lp_ready),
    .rd_instruc_valid(rd_instruc_valid), .rd_instruc_ready(rd_instruc_ready),
    .rd_instruc_offset(rd_instruc_offset), .rd_instruc_size(rd_instruc_size),
    .wr_instruc_valid(wr_instruc_valid), .wr_instruc_ready(wr_instruc_ready),
    .wr_instruc_offset(wr_instruc_offset), .wr_instruc_size(wr_instruc_size),
    .wrote_layerio_layer(wrote_layerio_layer), .wrote_inference(wrote_inference),
    .layer_idx(layer_idx), .busy(busy), .size_err(size_err)
  );

  always #5 clk = ~clk;

  typedef struct {int off; int sz;} exp_t;
  exp_t rdq[$], wrq[$];
  int   inf_exp = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation for every handshake / inference pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (rd_instruc_valid && rd_instruc_ready) begin
        chk("rd_expected", rdq.size() > 0, 1);
        if (rdq.size() > 0) begin
          e = rdq.pop_front();
          chk("rd_offset", rd_instruc_offset, e.off);
          chk("rd_size", rd_instruc_size, e.sz);
        end
      end
      if (wr_instruc_valid && wr_instruc_ready) begin
        chk("wr_expected", wrq.size() > 0, 1);
        if (wrq.size() > 0) begin
          e = wrq.pop_front();
          chk("wr_offset", wr_instruc_offset, e.off);
          chk("wr_size", wr_instruc_size, e.sz);
        end
      end
      if (wrote_inference) begin
        chk("inf_expected", inf_exp > 0, 1);
        if (inf_exp > 0) inf_exp--;
        chk("inf_after_rd", rdq.size(), 0);
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_rd_valid"}, rd_instruc_valid, 0);
    chk({tag, "_wr_valid"}, wr_instruc_valid, 0);
    chk({tag, "_rd_off"}, rd_instruc_offset, 0);
    chk({tag, "_rd_size"}, rd_instruc_size, 0);
    chk({tag, "_wr_off"}, wr_instruc_offset, 0);
    chk({tag, "_wr_size"}, wr_instruc_size, 0);
    chk({tag, "_lp_ready"}, lp_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_size_err"}, size_err, 0);
    chk({tag, "_wrote_inf"}, wrote_inference, 0);
    chk({tag, "_layer_idx"}, layer_idx, 0);
  endtask

  task automatic do_start(input int sz);
    @(posedge clk); #1 start = 1'b1; in_size = sz;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Presents layer params, waits for the handshake, then checks the 1-cycle latency.
  task automatic send_layer(input int wr, input bit last, input int idx,
                            input int roff, input int rsz, input int woff, input int wsz,
                            input bit push);
    bit got = 0;
    if (push) begin
      rdq.push_back('{roff, rsz});
      wrq.push_back('{woff, wsz});
    end
    @(posedge clk); #1 lp_valid = 1'b1; lp_total_writes = wr; lp_islastlayer = last;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (lp_ready) got = 1;
    end
    chk("lp_ready_seen", got, 1);
    @(posedge clk); #1 lp_valid = 1'b0;
    @(negedge clk);
    chk("lat_rd_valid", rd_instruc_valid, 1);
    chk("lat_wr_valid", wr_instruc_valid, 1);
    chk("layer_idx", layer_idx, idx);
  endtask

  task automatic complete_layer(input bit last);
    bit got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (!rd_instruc_valid && !wr_instruc_valid) got = 1;
    end
    chk("valids_drained", got, 1);
    if (last) inf_exp++;
    @(posedge clk); #1 wrote_layerio_layer = 1'b1;
    @(posedge clk); #1 wrote_layerio_layer = 1'b0;
    if (last) begin
      @(negedge clk);
      chk("inf_pulse", wrote_inference, 1);
      chk("busy_after_inf", busy, 0);
      @(negedge clk);
      chk("inf_one_cycle", wrote_inference, 0);
    end else begin
      @(negedge clk);
      chk("next_fetch_lp_ready", lp_ready, 1);
    end
  endtask

  task automatic single_layer_test();
    do_start(5);
    send_layer(6, 1, 0, 0, 5, 8, 6, 1);
    complete_layer(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle("rst");

    // Single layer
    single_layer_test();

    // Three layers: ping-pong offsets and size chaining
    do_start(5);
    send_layer(6, 0, 0, 0, 5, 8, 6, 1);
    complete_layer(0);
    send_layer(4, 0, 1, 8, 6, 0, 4, 1);
    complete_layer(0);
    send_layer(3, 1, 2, 0, 4, 8, 3, 1);
    complete_layer(1);

    // rd stalled 4 cycles, wr accepted immediately
    @(posedge clk); #1 rd_instruc_ready = 1'b0;
    do_start(5);
    send_layer(6, 1, 0, 0, 5, 8, 6, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_rd_valid", rd_instruc_valid, 1);
      chk("stall_rd_off", rd_instruc_offset, 0);
      chk("stall_rd_size", rd_instruc_size, 5);
      if (i == 1) chk("stall_wr_dropped", wr_instruc_valid, 0);
    end
    chk("stall_busy", busy, 1);
    @(posedge clk); #1 rd_instruc_ready = 1'b1;
    complete_layer(1);

    // Completion during ISSUE is remembered; size exactly HALF is legal
    @(posedge clk); #1 rd_instruc_ready = 1'b0;
    do_start(4);
    send_layer(8, 1, 0, 0, 4, 8, 8, 1);
    chk("half_no_err", size_err, 0);
    @(posedge clk); #1 wrote_layerio_layer = 1'b1;
    @(posedge clk); #1 wrote_layerio_layer = 1'b0;
    inf_exp++;
    @(posedge clk); #1 rd_instruc_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (wrote_inference) got = 1;
    end
    chk("pending_inf_seen", got, 1);
    chk("pending_busy", busy, 0);

    // Oversize clamps and sticky size_err
    do_start(5);
    send_layer(9, 1, 0, 0, 5, 8, 8, 1);
    chk("size_err_set", size_err, 1);
    complete_layer(1);
    do_start(10);
    send_layer(2, 1, 0, 0, 8, 8, 2, 1);
    chk("size_err_sticky", size_err, 1);
    complete_layer(1);

    // Reset during ISSUE drops everything
    @(posedge clk); #1 rd_instruc_ready = 1'b0; wr_instruc_ready = 1'b0;
    do_start(5);
    send_layer(6, 1, 0, 0, 5, 8, 6, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    @(posedge clk); #1 reset = 1'b0; rd_instruc_ready = 1'b1; wr_instruc_ready = 1'b1;
    single_layer_test();

    repeat (5) @(negedge clk);
    chk("rdq_drained", rdq.size(), 0);
    chk("wrq_drained", wrq.size(), 0);
    chk("inf_drained", inf_exp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
